// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger display pipeline.
// Holds the visible-area geometry, the grid step, the frog spawn point,
// the 2-bit move direction encoding and the move-request FSM states.
package frogger_pkg;

  localparam int POS_W     = 10;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int GRID_SIZE = 32;
  localparam int STEP      = GRID_SIZE;
  localparam int FROG_SIZE = 32;
  localparam int START_X   = 320;
  localparam int START_Y   = 448;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Single push-button conditioner.
// Two-flop synchroniser, stability counter that only commits a new level
// after DEBOUNCE_CYCLES agreeing samples, and a one-cycle press strobe on
// the debounced rising edge.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   btn_raw  raw asynchronous button input, active-high
//   level    debounced button level
//   press    one-cycle pulse on a debounced 0->1 transition
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      // synchroniser stages
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      level_d <= level;
      // count only while the synced input disagrees with the accepted level;
      // any return to agreement (a bounce) restarts the count
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/frog_movement.sv
// Frog position controller feeding the VGA renderer.
// Debounces four direction buttons, latches a single pending move per press
// and applies it on the next rising edge of vsync so the sprite only moves
// between frames. The position is clamped to the visible area.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   btn_up/down/left/right   raw asynchronous buttons, active-high
//   vsync                    active-high vertical sync, synchronous to clk
//   frog_x, frog_y           frog top-left corner in pixels (multiples of STEP)
//   move_pulse               one-cycle strobe when the position changes
module frog_movement #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP            = frogger_pkg::STEP,
  parameter int H_DISPLAY       = frogger_pkg::H_DISPLAY,
  parameter int V_DISPLAY       = frogger_pkg::V_DISPLAY,
  parameter int FROG_SIZE       = frogger_pkg::FROG_SIZE,
  parameter int START_X         = frogger_pkg::START_X,
  parameter int START_Y         = frogger_pkg::START_Y
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       vsync,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic       move_pulse
);

  import frogger_pkg::*;

  localparam logic [9:0] STEP_V  = 10'(STEP);
  localparam logic [9:0] X_LIMIT = 10'(H_DISPLAY - FROG_SIZE - STEP);
  localparam logic [9:0] Y_LIMIT = 10'(V_DISPLAY - FROG_SIZE - STEP);

  logic [3:0] press;
  logic [3:0] btn_level_unused;
  logic       vsync_d;
  logic       vsync_rise;
  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  dir_e       sel_dir;
  logic [9:0] x_d, y_d;
  logic       pulse_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up),
    .level(btn_level_unused[0]), .press(press[0]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_raw(btn_down),
    .level(btn_level_unused[1]), .press(press[1]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .btn_raw(btn_left),
    .level(btn_level_unused[2]), .press(press[2]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .btn_raw(btn_right),
    .level(btn_level_unused[3]), .press(press[3]));

  // Clamped single-step moves: a step that would leave the visible area
  // leaves the coordinate unchanged.
  function automatic logic [9:0] step_x(input dir_e dir, input logic [9:0] x);
    step_x = x;
    if (dir == DIR_LEFT && x >= STEP_V)
      step_x = x - STEP_V;
    else if (dir == DIR_RIGHT && x <= X_LIMIT)
      step_x = x + STEP_V;
  endfunction

  function automatic logic [9:0] step_y(input dir_e dir, input logic [9:0] y);
    step_y = y;
    if (dir == DIR_UP && y >= STEP_V)
      step_y = y - STEP_V;
    else if (dir == DIR_DOWN && y <= Y_LIMIT)
      step_y = y + STEP_V;
  endfunction

  assign vsync_rise = vsync & ~vsync_d;

  always_comb begin
    sel_dir = DIR_RIGHT;
    if (press[0])      sel_dir = DIR_UP;
    else if (press[1]) sel_dir = DIR_DOWN;
    else if (press[2]) sel_dir = DIR_LEFT;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = frog_x;
    y_d     = frog_y;
    pulse_d = 1'b0;
    case (state_q)
      // a press coinciding with vsync_rise is only captured here; it is
      // applied at the following frame edge
      IDLE: begin
        if (|press) begin
          state_d = ARMED;
          dir_d   = sel_dir;
        end
      end
      ARMED: begin
        if (vsync_rise) begin
          x_d     = step_x(dir_q, frog_x);
          y_d     = step_y(dir_q, frog_y);
          pulse_d = (x_d != frog_x) || (y_d != frog_y);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      vsync_d    <= 1'b0;
      frog_x     <= 10'(START_X);
      frog_y     <= 10'(START_Y);
      move_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      vsync_d    <= vsync;
      frog_x     <= x_d;
      frog_y     <= y_d;
      move_pulse <= pulse_d;
    end
  end

endmodule
